// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Brief    : Multi-cycle ALU with valid/ready handshakes, barrel shifts,
//             iterative shift-add multiplier and restoring divider, full NZCV.
//             Optional divider is built when ALU_DIV_EN is defined; without
//             it DIV completes in one cycle with result 0 and nzcv 4'b0101.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzcv
);

    localparam logic [4:0] c_OP_ADD  = 5'b00000;
    localparam logic [4:0] c_OP_SUB  = 5'b00001;
    localparam logic [4:0] c_OP_MUL  = 5'b00010;
    localparam logic [4:0] c_OP_DIV  = 5'b00011;
    localparam logic [4:0] c_OP_AND  = 5'b00100;
    localparam logic [4:0] c_OP_NAND = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_NOR  = 5'b00111;
    localparam logic [4:0] c_OP_XOR  = 5'b01000;
    localparam logic [4:0] c_OP_XNOR = 5'b01001;
    localparam logic [4:0] c_OP_SHL  = 5'b01010;
    localparam logic [4:0] c_OP_SHR  = 5'b01011;
    localparam logic [4:0] c_OP_ROL  = 5'b01100;
    localparam logic [4:0] c_OP_ROR  = 5'b01101;
    localparam logic [4:0] c_OP_ASR  = 5'b01110;
    localparam logic [4:0] c_OP_CMP  = 5'b01111;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(WIDTH - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_prod;     // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]     r_opd;      // MUL: multiplicand; DIV: divisor
    logic                 w_accept;
    logic                 w_start_iter;
    logic                 w_last;

    // single-cycle datapath wires
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_shamt_nz;
    logic [WIDTH:0]       w_add_full;
    logic [WIDTH:0]       w_sub_full;
    logic [WIDTH:0]       w_shl_full;
    logic [WIDTH:0]       w_shr_full;
    logic [WIDTH:0]       w_asr_full;
    logic [WIDTH-1:0]     w_rol;
    logic [WIDTH-1:0]     w_ror;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c;
    logic                 w_v;
    logic [3:0]           w_nzcv;

    // iterative datapath wires
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_iter_next;
    logic [WIDTH-1:0]     w_iter_res;
    logic                 w_iter_c;
    logic [3:0]           w_iter_nzcv;

`ifdef ALU_DIV_EN
    logic                 r_is_mul;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_trial;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;
`endif

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == c_CNT_LAST);
`ifdef ALU_DIV_EN
    assign w_start_iter = (op == c_OP_MUL) || ((op == c_OP_DIV) && (b != '0));
`else
    assign w_start_iter = (op == c_OP_MUL);
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_next;
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_next = w_start_iter ? c_ST_BUSY : c_ST_DONE;
            c_ST_BUSY: if (w_last)   w_state_next = c_ST_DONE;
            c_ST_DONE: if (out_ready) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == c_ST_IDLE);
        out_valid = (r_state == c_ST_DONE);
    end

    assign w_shamt    = b[SHAMT_W-1:0];
    assign w_shamt_nz = |w_shamt;
    assign w_add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    assign w_sub_full = {1'b0, a} - {1'b0, b};
    // An extra guard bit on the far side of each shifter catches the last bit shifted out
    assign w_shl_full = {1'b0, a} << w_shamt;
    assign w_shr_full = {a, 1'b0} >> w_shamt;
    assign w_asr_full = $signed({a, 1'b0}) >>> w_shamt;

    // rotators: index arithmetic wraps modulo WIDTH because WIDTH is a power of two
    always_comb begin
        w_rol = '0;
        w_ror = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rol[i] = a[SHAMT_W'(i) - w_shamt];
            w_ror[i] = a[SHAMT_W'(i) + w_shamt];
        end
    end

    // single-cycle result and carry/overflow selection
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res = w_add_full[WIDTH-1:0];
                w_c   = w_add_full[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SUB, c_OP_CMP: begin
                w_res = w_sub_full[WIDTH-1:0];
                w_c   = ~w_sub_full[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
`ifdef ALU_DIV_EN
            // only divide-by-zero reaches this single-cycle path
            c_OP_DIV: begin
                w_res = '1;
                w_v   = 1'b1;
            end
`else
            c_OP_DIV: begin
                w_res = '0;
                w_v   = 1'b1;
            end
`endif
            c_OP_AND:  w_res = a & b;
            c_OP_NAND: w_res = ~(a & b);
            c_OP_OR:   w_res = a | b;
            c_OP_NOR:  w_res = ~(a | b);
            c_OP_XOR:  w_res = a ^ b;
            c_OP_XNOR: w_res = ~(a ^ b);
            c_OP_SHL: begin
                w_res = w_shl_full[WIDTH-1:0];
                w_c   = w_shl_full[WIDTH];
            end
            c_OP_SHR: begin
                w_res = w_shr_full[WIDTH:1];
                w_c   = w_shr_full[0];
            end
            c_OP_ASR: begin
                w_res = w_asr_full[WIDTH:1];
                w_c   = w_asr_full[0];
            end
            c_OP_ROL: begin
                w_res = w_rol;
                w_c   = w_shamt_nz & w_rol[0];
            end
            c_OP_ROR: begin
                w_res = w_ror;
                w_c   = w_shamt_nz & w_ror[WIDTH-1];
            end
            default: w_res = '0;
        endcase
    end

    assign w_nzcv = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};

    // shift-add step: conditionally add multiplicand into the high half, then shift right
    assign w_mul_sum  = r_prod[0] ? ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opd})
                                  : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
    assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    // restoring step: shift next dividend bit into remainder, subtract when it fits
    assign w_div_shift = r_prod[2*WIDTH-1:WIDTH-1];
    assign w_div_trial = w_div_shift - {1'b0, r_opd};
    assign w_div_ge    = ~w_div_trial[WIDTH];
    assign w_div_next  = {(w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_prod[WIDTH-2:0], w_div_ge};
    assign w_iter_next = r_is_mul ? w_mul_next : w_div_next;
    assign w_iter_c    = r_is_mul & (|w_iter_next[2*WIDTH-1:WIDTH]);
`else
    assign w_iter_next = w_mul_next;
    assign w_iter_c    = |w_iter_next[2*WIDTH-1:WIDTH];
`endif

    assign w_iter_res  = w_iter_next[WIDTH-1:0];
    assign w_iter_nzcv = {w_iter_res[WIDTH-1], (w_iter_res == '0), w_iter_c, 1'b0};

    // operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_opd    <= '0;
            result   <= '0;
            nzcv     <= '0;
`ifdef ALU_DIV_EN
            r_is_mul <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt <= '0;
            if (w_start_iter) begin
                r_prod   <= {{WIDTH{1'b0}}, ((op == c_OP_MUL) ? b : a)};
                r_opd    <= (op == c_OP_MUL) ? a : b;
`ifdef ALU_DIV_EN
                r_is_mul <= (op == c_OP_MUL);
`endif
            end else begin
                result <= w_res;
                nzcv   <= w_nzcv;
            end
        end else if (r_state == c_ST_BUSY) begin
            r_prod <= w_iter_next;
            r_cnt  <= r_cnt + SHAMT_W'(1);
            if (w_last) begin
                result <= w_iter_res;
                nzcv   <= w_iter_nzcv;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Brief    : Directed self-checking bench for alu_seq (WIDTH=16). DIV
//             expectations follow ALU_DIV_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = 5'b0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic [3:0]  nzcv;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .nzcv      (nzcv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency, check outputs, then consume the result
    task automatic run_op(input string tag, input logic [4:0] o, input logic [15:0] aa,
                          input logic [15:0] bb, input logic ci, input logic [15:0] er,
                          input logic [3:0] en, input int elat);
        int  lat;
        bit  seen;
        bit  rdy_bad;
        @(negedge clk);
        op = o; a = aa; b = bb; c_in = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1;
        lat = 1; seen = 1'b0; rdy_bad = 1'b0;
        while (!seen && lat <= 40) begin
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            if (out_valid === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_res"}, {16'h0, result}, {16'h0, er});
        chk({tag, "_nzcv"}, {28'h0, nzcv}, {28'h0, en});
        chk({tag, "_in_ready_low"}, {31'h0, rdy_bad}, 32'h0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk({tag, "_ov_drop"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        bit hold_bad;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_result", {16'h0, result}, 32'h0);
        chk("rst_nzcv", {28'h0, nzcv}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        run_op("add_ovf",  5'b00000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1001, 1);
        run_op("add_cin",  5'b00000, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0110, 1);
        run_op("sub_neg",  5'b00001, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 4'b1000, 1);
        run_op("cmp_eq",   5'b01111, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b0110, 1);
        run_op("mul_ovf",  5'b00010, 16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b0110, 17);
        run_op("mul_hi",   5'b00010, 16'h1234, 16'h0010, 1'b0, 16'h2340, 4'b0010, 17);
`ifdef ALU_DIV_EN
        run_op("div",      5'b00011, 16'h0064, 16'h0007, 1'b0, 16'h000E, 4'b0000, 17);
        run_op("div_zero", 5'b00011, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 4'b1001, 1);
`else
        run_op("div",      5'b00011, 16'h0064, 16'h0007, 1'b0, 16'h0000, 4'b0101, 1);
        run_op("div_zero", 5'b00011, 16'h1234, 16'h0000, 1'b0, 16'h0000, 4'b0101, 1);
`endif
        run_op("rol",      5'b01100, 16'h8001, 16'h0001, 1'b0, 16'h0003, 4'b0010, 1);
        run_op("ror",      5'b01101, 16'h0001, 16'h0001, 1'b0, 16'h8000, 4'b1010, 1);
        run_op("asr",      5'b01110, 16'h8000, 16'h000F, 1'b0, 16'hFFFF, 4'b1000, 1);
        run_op("shr",      5'b01011, 16'h0003, 16'h0001, 1'b0, 16'h0001, 4'b0010, 1);
        run_op("shl_out",  5'b01010, 16'h8000, 16'h0001, 1'b0, 16'h0000, 4'b0110, 1);
        run_op("shl_zero", 5'b01010, 16'hABCD, 16'h0000, 1'b0, 16'hABCD, 4'b1000, 1);
        run_op("and",      5'b00100, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 4'b1000, 1);
        run_op("xnor",     5'b01001, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 4'b0100, 1);
        run_op("nor",      5'b00111, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4'b1000, 1);
        run_op("undef",    5'b10011, 16'h1234, 16'h5678, 1'b1, 16'h0000, 4'b0100, 1);

        // hold the result in DONE for 5 cycles with out_ready low
        @(negedge clk);
        op = 5'b00000; a = 16'h0001; b = 16'h0002; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hold_ov", {31'h0, out_valid}, 32'h1);
        hold_bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (result !== 16'h0003 || nzcv !== 4'b0000 || in_ready !== 1'b0 || out_valid !== 1'b1)
                hold_bad = 1'b1;
        end
        chk("hold_stable", {31'h0, hold_bad}, 32'h0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        op = 5'b00010; a = 16'h0003; b = 16'h0005; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_result", {16'h0, result}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk); rst_n = 1'b1;
        run_op("post_rst_add", 5'b00000, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
